// File: rtl/sa_ser_pkg.sv
// Shared types for the systolic-array result serializer:
// FSM state encoding, UART byte width and word-to-byte helper.
package sa_ser_pkg;

  localparam int SER_W_DATA = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_CKSUM = 3'd4
  } ser_state_e;

  function automatic int bytes_per_word(
    input int w_word,
    input int w_data
  );
    return w_word / w_data;
  endfunction

endpackage

// File: rtl/sa_byte_index_ctr.sv
// Word/byte index counter for the result serializer.
// Byte index wraps into the word index; flags the final byte.
module sa_byte_index_ctr
  import sa_ser_pkg::*;
#(
  parameter int COL = 56,
  parameter int BPW = 4,
  localparam int WIW = (COL > 1) ? $clog2(COL) : 1,
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           adv_i,
  output logic [WIW-1:0] word_idx_o,
  output logic [BIW-1:0] byte_idx_o,
  output logic           last_o
);

  localparam logic [WIW-1:0] WORD_LAST = WIW'(COL - 1);
  localparam logic [BIW-1:0] BYTE_LAST = BIW'(BPW - 1);

  logic [WIW-1:0] word_q, word_d;
  logic [BIW-1:0] byte_q, byte_d;
  logic           wrap;

  assign wrap = (byte_q == BYTE_LAST);

  always_comb begin
    word_d = word_q;
    byte_d = byte_q;
    unique case (1'b1)
      clr_i: begin
        word_d = '0;
        byte_d = '0;
      end
      !clr_i && adv_i && wrap: begin
        byte_d = '0;
        word_d = word_q + 1'b1;
      end
      !clr_i && adv_i && !wrap: begin
        byte_d = byte_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      byte_q <= '0;
    end else begin
      word_q <= word_d;
      byte_q <= byte_d;
    end
  end

  assign word_idx_o = word_q;
  assign byte_idx_o = byte_q;
  assign last_o     = wrap && (word_q == WORD_LAST);

endmodule

// File: rtl/sa_result_serializer.sv
// Snapshots COL result words and streams them LSB-first to uart_tx.
// Define SER_CHECKSUM_EN to append an XOR checksum byte per frame.
module sa_result_serializer
  import sa_ser_pkg::*;
#(
  parameter int COL    = 56,
  parameter int W_WORD = 32,
  parameter int W_DATA = SER_W_DATA
) (
  input  logic                  i_clk,
  input  logic                  i_Rst_L,
  input  logic                  i_load,
  input  logic [COL*W_WORD-1:0] i_words,
  output logic                  o_tx_dv,
  output logic [W_DATA-1:0]     o_tx_byte,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_overrun
);

  localparam int BPW  = bytes_per_word(W_WORD, W_DATA);
  localparam int WIW  = (COL > 1) ? $clog2(COL) : 1;
  localparam int BIW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int OFFW = (COL * W_WORD > 1) ? $clog2(COL * W_WORD) : 1;

  ser_state_e state_q, state_d;

  logic [COL*W_WORD-1:0] shadow_q;
  logic                  overrun_q;
  logic                  load_acc;
  logic                  adv;
  logic [WIW-1:0]        word_idx;
  logic [BIW-1:0]        byte_idx;
  logic                  last;
  logic [OFFW-1:0]       off;
  logic [W_DATA-1:0]     payload;

  sa_byte_index_ctr #(
    .COL (COL),
    .BPW (BPW)
  ) u_idx (
    .clk_i      (i_clk),
    .rst_ni     (i_Rst_L),
    .clr_i      (load_acc),
    .adv_i      (adv),
    .word_idx_o (word_idx),
    .byte_idx_o (byte_idx),
    .last_o     (last)
  );

`ifdef SER_CHECKSUM_EN
  logic [W_DATA-1:0] cks_q;
  logic              cks_sel_q;
`endif

  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          load_acc = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef SER_CHECKSUM_EN
          if (cks_sel_q) state_d = ST_DONE;
          else if (last) state_d = ST_CKSUM;
`else
          if (last) state_d = ST_DONE;
`endif
          else begin
            adv     = 1'b1;
            state_d = ST_SEND;
          end
        end
      end
`ifdef SER_CHECKSUM_EN
      ST_CKSUM: state_d = ST_SEND;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= i_load && (state_q != ST_IDLE);
      if (load_acc) shadow_q <= i_words;
    end
  end

`ifdef SER_CHECKSUM_EN
  // Payload bytes fold into the checksum as they are offered.
  always_ff @(posedge i_clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cks_q     <= '0;
      cks_sel_q <= 1'b0;
    end else if (load_acc) begin
      cks_q     <= '0;
      cks_sel_q <= 1'b0;
    end else begin
      if (state_q == ST_SEND && !cks_sel_q) cks_q <= cks_q ^ payload;
      if (state_q == ST_CKSUM) cks_sel_q <= 1'b1;
    end
  end
`endif

  assign off = OFFW'(word_idx) * OFFW'(W_WORD)
             + OFFW'(byte_idx) * OFFW'(W_DATA);
  assign payload = shadow_q[off +: W_DATA];

  always_comb begin
    o_tx_byte = '0;
    if (state_q == ST_SEND || state_q == ST_WAIT) begin
      o_tx_byte = payload;
`ifdef SER_CHECKSUM_EN
      if (cks_sel_q) o_tx_byte = cks_q;
`endif
    end
  end

  assign o_tx_dv      = (state_q == ST_SEND);
  assign o_busy       = (state_q == ST_SEND) || (state_q == ST_WAIT)
                     || (state_q == ST_CKSUM);
  assign o_frame_done = (state_q == ST_DONE);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_sa_result_serializer.sv
// Randomized self-checking bench for sa_result_serializer (COL=2).
// Expected byte stream comes from a queue-based model of the frame.
module tb_sa_result_serializer;

  localparam int COL = 2;
  localparam int WW  = 32;
  localparam int WD  = 8;
  localparam int NB  = COL * (WW / WD);
`ifdef SER_CHECKSUM_EN
  localparam int NF  = NB + 1;
`else
  localparam int NF  = NB;
`endif

  logic              i_clk = 1'b0;
  logic              i_Rst_L = 1'b0;
  logic              i_load = 1'b0;
  logic              i_tx_done = 1'b0;
  logic [COL*WW-1:0] i_words = '0;
  logic              o_tx_dv;
  logic [WD-1:0]     o_tx_byte;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_overrun;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fd_cnt = 0;
  logic [7:0] expq[$];

  always #5 i_clk = ~i_clk;

  sa_result_serializer #(
    .COL    (COL),
    .W_WORD (WW),
    .W_DATA (WD)
  ) dut (
    .i_clk        (i_clk),
    .i_Rst_L      (i_Rst_L),
    .i_load       (i_load),
    .i_words      (i_words),
    .o_tx_dv      (o_tx_dv),
    .o_tx_byte    (o_tx_byte),
    .i_tx_done    (i_tx_done),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always @(negedge i_clk) begin
    if (o_tx_dv) dv_cnt++;
    if (o_frame_done) fd_cnt++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Frame = whole vector as a byte stream, lowest byte first.
  task automatic build(input logic [COL*WW-1:0] w);
    logic [COL*WW-1:0] s;
`ifdef SER_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
`endif
    s = w;
    expq.delete();
    for (int k = 0; k < NB; k++) begin
      expq.push_back(s[7:0]);
`ifdef SER_CHECKSUM_EN
      x = x ^ s[7:0];
`endif
      s = s >> 8;
    end
`ifdef SER_CHECKSUM_EN
    expq.push_back(x);
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_dv"}, o_tx_dv, 0);
    chk({tag, "_byte"}, o_tx_byte, 0);
    chk({tag, "_fd"}, o_frame_done, 0);
    chk({tag, "_ovr"}, o_overrun, 0);
  endtask

  task automatic run_frame(
    input logic [COL*WW-1:0] w,
    input int                dly,
    input int                ovr_at,
    input int                abort_at,
    input bit                spur
  );
    int base_dv;
    int base_fd;
    int d;
    build(w);
    base_dv = dv_cnt;
    base_fd = fd_cnt;
    i_words = w;
    i_load  = 1'b1;
    step();
    i_load  = 1'b0;
    for (int i = 0; i < NF; i++) begin
      chk("dv", o_tx_dv, 1);
      chk("busy", o_busy, 1);
      chk("byte", o_tx_byte, expq[i]);
      if (spur && i == 2) i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      d = (dly > 0) ? dly : $urandom_range(1, 6);
      for (int c = 1; c < d; c++) begin
        chk("hold_dv", o_tx_dv, 0);
        chk("hold_byte", o_tx_byte, expq[i]);
        step();
      end
      if (i == abort_at) begin
        i_Rst_L = 1'b0;
        #1;
        chk_quiet("abort");
        step();
        step();
        i_Rst_L = 1'b1;
        step();
        chk("abort_fd", fd_cnt - base_fd, 0);
        chk("abort_idle", o_busy, 0);
        return;
      end
      chk("wait_byte", o_tx_byte, expq[i]);
      i_tx_done = 1'b1;
      if (i == ovr_at) begin
        i_load  = 1'b1;
        i_words = ~w;
      end
      step();
      i_tx_done = 1'b0;
      if (i == ovr_at) begin
        i_load = 1'b0;
        chk("overrun", o_overrun, 1);
      end
`ifdef SER_CHECKSUM_EN
      if (i == NF - 2) begin
        chk("cksum_gap", o_tx_dv, 0);
        step();
      end
`endif
    end
    chk("frame_done", o_frame_done, 1);
    chk("busy_off", o_busy, 0);
    chk("dv_count", dv_cnt - base_dv, NF);
    step();
    chk("fd_pulse", o_frame_done, 0);
    chk("fd_count", fd_cnt - base_fd, 1);
  endtask

  initial begin
    logic [COL*WW-1:0] w;
    #1;
    chk_quiet("reset");
    step();
    i_Rst_L = 1'b1;
    step();
    chk_quiet("idle");

    w = {32'hDEADBEEF, 32'h03020100};
    run_frame(w, 5, -1, -1, 1'b0);
    run_frame(w, 9, -1, -1, 1'b0);
    run_frame(w, 5, 3, -1, 1'b0);
    run_frame({$urandom, $urandom}, 3, NF - 1, -1, 1'b0);

    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    chk("spur_idle_dv", o_tx_dv, 0);
    chk("spur_idle_busy", o_busy, 0);
    run_frame(w, 4, -1, -1, 1'b1);

    run_frame(w, 5, -1, 5, 1'b0);
    run_frame(w, 2, -1, -1, 1'b0);

    repeat (6) begin
      run_frame({$urandom, $urandom}, 0, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
